// File: rtl/fir_decimator_buffer_if.sv
// Sample stream in, decimated FIFO stream out; master = producer/consumer side, slave = buffer.
interface fir_decimator_buffer_if #(
  parameter int N     = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  data_in;
  logic          in_en;
  logic [N-1:0]  data_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clear_ovf;

  modport master (
    output data_in, in_en, out_ready, clear_ovf,
    input  data_out, out_valid, fifo_count, overflow
  );

  modport slave (
    input  data_in, in_en, out_ready, clear_ovf,
    output data_out, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/fir_decimator_buffer.sv
// Decimate-by-DECIM then FWFT FIFO; FIR_DECIM_AVG_EN selects frame averaging over picking.
// Latency: one clock from decimation event to out_valid. Backpressure: full FIFO drops the event and sets sticky overflow.
module fir_decimator_buffer #(
  parameter int N     = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  fir_decimator_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(DECIM);

  logic [DW-1:0] phase_q, phase_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  mem_q [DEPTH];

  logic          empty, full, dec_evt, pop, push;
  logic [N-1:0]  push_val;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign dec_evt = bus.in_en && (phase_q == DW'(DECIM - 1));
  // out_valid is registered state, so a push into an empty FIFO is never popped the same cycle.
  assign pop     = !empty && bus.out_ready;
  assign push    = dec_evt && (!full || pop);

`ifdef FIR_DECIM_AVG_EN
  localparam int AW = N + DW;
  logic [AW-1:0] acc_q, acc_d, sum;

  assign sum      = acc_q + AW'(bus.data_in);
  assign push_val = N'(sum >> DW);

  always_comb begin
    acc_d = acc_q;
    if (bus.in_en) acc_d = dec_evt ? '0 : sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign push_val = bus.data_in;
`endif

  always_comb begin
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.in_en) phase_d = phase_q + DW'(1);
    if (push)      wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as clear_ovf must leave the flag set.
    if (dec_evt && !push) ovf_d = 1'b1;
    else if (bus.clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_val;
  end

  assign bus.out_valid  = !empty;
  assign bus.data_out   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_fir_decimator_buffer.sv
// Directed bench for fir_decimator_buffer with a queue-based reference model checked every cycle.
module tb_fir_decimator_buffer;
  localparam int N     = 16;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_decimator_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  fir_decimator_buffer #(.N(N), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int m_q[$];
  int m_en_cnt;
  int m_sum;
  bit m_ovf;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Value of ramp frame k (samples 4k-3 .. 4k): pick keeps 4k, average is floor((16k-6)/4) = 4k-2.
  function automatic int ramp_frame(input int k);
`ifdef FIR_DECIM_AVG_EN
    return 4 * k - 2;
`else
    return 4 * k;
`endif
  endfunction

  // Reference model: counts enabled samples, keeps the frame sum, and a bounded queue of outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_en_cnt = 0;
      m_sum    = 0;
      m_ovf    = 1'b0;
    end else begin
      bit do_pop, ev, drop;
      int val;
      do_pop = (m_q.size() > 0) && bus.out_ready;
      ev     = bus.in_en && ((m_en_cnt % DECIM) == DECIM - 1);
`ifdef FIR_DECIM_AVG_EN
      val = (m_sum + int'(bus.data_in)) / DECIM;
`else
      val = int'(bus.data_in);
`endif
      if (bus.in_en) begin
        m_en_cnt++;
        m_sum = ev ? 0 : m_sum + int'(bus.data_in);
      end
      if (do_pop) void'(m_q.pop_front());
      drop = ev && (m_q.size() >= DEPTH);
      if (ev && !drop) m_q.push_back(val);
      if (drop) m_ovf = 1'b1;
      else if (bus.clear_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_valid", int'(bus.out_valid), int'(m_q.size() > 0));
      chk("cyc_data", int'(bus.data_out), (m_q.size() > 0) ? m_q[0] : 0);
      chk("cyc_count", int'(bus.fifo_count), m_q.size());
      chk("cyc_ovf", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic drive(input bit en, input int din, input bit rdy, input bit clr);
    bus.in_en     = en;
    bus.data_in   = N'(din);
    bus.out_ready = rdy;
    bus.clear_ovf = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.in_en     = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_ovf", int'(bus.overflow), 0);

    // Ramp with consumer always ready: one-cycle valid pulses.
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      if (i % 4 == 0) begin
        chk("ramp_valid", int'(bus.out_valid), 1);
        chk("ramp_data", int'(bus.data_out), ramp_frame(i / 4));
      end else if (i % 4 == 1 && i > 1) begin
        chk("ramp_gone", int'(bus.out_valid), 0);
      end
    end
    drive(1'b0, 0, 1'b1, 1'b0);

    // Gapped input: data follows the clock index, only even cycles enabled.
    for (int k = 0; k < 16; k++) begin
      drive(k % 2 == 0, k, 1'b1, 1'b0);
`ifdef FIR_DECIM_AVG_EN
      if (k == 6)  chk("gap_first", int'(bus.data_out), 3);
      if (k == 14) chk("gap_second", int'(bus.data_out), 11);
`else
      if (k == 6)  chk("gap_first", int'(bus.data_out), 6);
      if (k == 14) chk("gap_second", int'(bus.data_out), 14);
`endif
      if (k == 7) chk("gap_gone", int'(bus.out_valid), 0);
    end

    // Overflow: 9 events with the consumer stalled.
    for (int i = 1; i <= 36; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      if (i == 32) chk("ovf_pre", int'(bus.overflow), 0);
    end
    chk("ovf_count", int'(bus.fifo_count), 8);
    chk("ovf_set", int'(bus.overflow), 1);
    for (int j = 1; j <= 8; j++) begin
      chk("drain_order", int'(bus.data_out), ramp_frame(j));
      drive(1'b0, 0, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(bus.out_valid), 0);
    chk("drain_sticky", int'(bus.overflow), 1);
    drive(1'b0, 0, 1'b0, 1'b1);
    chk("ovf_clear", int'(bus.overflow), 0);

    // Full FIFO with a pop on the event cycle, then a drop coinciding with clear_ovf.
    for (int i = 1; i <= 35; i++) drive(1'b1, i, 1'b0, 1'b0);
    drive(1'b1, 36, 1'b1, 1'b0);
    chk("fullpop_count", int'(bus.fifo_count), 8);
    chk("fullpop_ovf", int'(bus.overflow), 0);
    chk("fullpop_head", int'(bus.data_out), ramp_frame(2));
    for (int i = 37; i <= 39; i++) drive(1'b1, i, 1'b0, 1'b0);
    drive(1'b1, 40, 1'b0, 1'b1);
    chk("drop_clr_ovf", int'(bus.overflow), 1);
    chk("drop_clr_count", int'(bus.fifo_count), 8);
    for (int j = 2; j <= 9; j++) begin
      if (j == 9) chk("tail_value", int'(bus.data_out), ramp_frame(9));
      drive(1'b0, 0, 1'b1, 1'b0);
    end

    // Mid-stream asynchronous reset with five samples stored and overflow set.
    for (int i = 1; i <= 22; i++) drive(1'b1, i, 1'b0, 1'b0);
    chk("prerst_count", int'(bus.fifo_count), 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(bus.fifo_count), 0);
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_data", int'(bus.data_out), 0);
    chk("arst_ovf", int'(bus.overflow), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 100; i <= 102; i++) drive(1'b1, i, 1'b0, 1'b0);
    chk("post_rst_none", int'(bus.fifo_count), 0);
    drive(1'b1, 103, 1'b0, 1'b0);
    chk("post_rst_count", int'(bus.fifo_count), 1);
`ifdef FIR_DECIM_AVG_EN
    chk("post_rst_data", int'(bus.data_out), 101);
`else
    chk("post_rst_data", int'(bus.data_out), 103);
`endif
    drive(1'b0, 0, 1'b1, 1'b0);

`ifdef FIR_DECIM_AVG_EN
    drive(1'b1, 10, 1'b0, 1'b0);
    drive(1'b1, 20, 1'b0, 1'b0);
    drive(1'b1, 30, 1'b0, 1'b0);
    drive(1'b1, 40, 1'b0, 1'b0);
    chk("avg_25", int'(bus.data_out), 25);
    drive(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 65535, 1'b0, 1'b0);
    chk("avg_max", int'(bus.data_out), 65535);
    drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b1, 2, 1'b0, 1'b0);
    chk("avg_trunc", int'(bus.data_out), 1);
    drive(1'b0, 0, 1'b1, 1'b0);
`endif

    repeat (3) drive(1'b0, 0, 1'b1, 1'b0);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_decimator_buffer.md
# fir_decimator_buffer

Downstream stage of the FIR filter. It takes the filter's output sample stream, decimates it by a fixed factor, and buffers the decimated samples in a small FIFO. Samples leave through a valid/ready handshake toward the consumer (DMA, serializer or display logic). Overflow is reported with a sticky flag, so a stalled consumer never corrupts ordering silently.

## Interface
- `N`, 16: sample width; matches the FIR output width.
- `DECIM`, 4: decimation factor; power of two, 2..16.
- `DEPTH`, 8: FIFO depth in samples; power of two, 2..64.

Ports:
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  N  FIR output sample (unsigned), sampled on each rising edge.
- `in_en`  in  1  qualifies `data_in`; the cycle is ignored when low.
- `data_out`  out  N  FIFO head sample; 0 when `out_valid`=0.
- `out_valid`  out  1  high when FIFO is non-empty.
- `out_ready`  in  1  consumer accepts the head sample this cycle.
- `fifo_count`  out  log2(DEPTH)+1  number of stored samples, 0..DEPTH.
- `overflow`  out  1  sticky; set when a decimated sample is dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Phase counter runs 0..DECIM-1.
  - It advances only on cycles with `in_en`=1 and wraps to 0 after DECIM-1.
  - With `in_en`=0 it holds its value.
- Decimation event: `in_en`=1 and phase==DECIM-1. The decimated value is pushed on that edge.
  - Default mode: the decimated value is that cycle's `data_in`.
  - Averaging mode: see Configuration.
- FIFO:
  - Circular buffer with read and write pointers, each log2(DEPTH) bits; pointers wrap modulo DEPTH.
  - Pop = `out_valid` && `out_ready`.
  - Push = decimation event and (count<DEPTH or pop in the same cycle).
- Simultaneous push and pop:
  - `fifo_count` is unchanged.
  - This is legal when full: the pop frees a slot and the push is accepted, with no overflow.
  - When empty, a push with `out_ready`=1 is not popped the same cycle, because `out_valid` is still 0.
- Full with no pop: the decimation event is dropped and `overflow` is set at that edge. Stored contents and their order are untouched.
- `overflow` clearing:
  - It is cleared only by `clear_ovf`=1 or reset.
  - If a drop and `clear_ovf` occur in the same cycle, set wins and `overflow` stays 1.
- `data_out` is combinational from memory[rd_ptr], gated to 0 when empty (first-word-fall-through).
- Reset (`reset`=0), effective immediately at any time, including mid-stream:
  - Phase, pointers and accumulator go to 0; `fifo_count`=0 and `overflow`=0.
  - `out_valid`=0 and `data_out`=0.
  - Memory contents need not be cleared.

## Timing
- Latency: decimation event at edge E, then `out_valid`=1 and `data_out`=value in the cycle after E (1 clock).
- Throughput: at most one push per DECIM enabled cycles and one pop per cycle.
- `fifo_count` and `overflow` update on the same edge as the push or pop that changes them.
- There are no combinational paths from `out_ready` to `out_valid` or `data_out`.
- Reset release: the first enabled cycle after reset deasserts is phase 0.

## Configuration
- Macro: `FIR_DECIM_AVG_EN`.
- Defined (averaging mode):
  - An accumulator of width N+log2(DECIM) sums all DECIM enabled samples of the frame, including the event-cycle `data_in`.
  - The pushed value is sum >> log2(DECIM), truncated, never saturating.
  - The accumulator restarts from 0 for the next frame.
  - It clears on reset and holds while `in_en`=0.
- Undefined: pick mode, where only the event-cycle sample is kept. No accumulator is synthesized.
- Ports, handshake and latency are identical in both builds.

## Test plan
- Reset: drive `reset`=0 mid-stream with `fifo_count`=5 → `fifo_count`=0, `out_valid`=0, `data_out`=0, `overflow`=0 immediately. After release, the 4th enabled sample is the first one pushed.
- Pick mode (N=16, DECIM=4, DEPTH=8):
  - Stimulus: `data_in`=1,2,3,… with `in_en`=1 and `out_ready`=1.
  - Expected: `data_out`=4,8,12,…, each valid for exactly one cycle, the cycle after samples 4,8,12.
- Averaging mode with `FIR_DECIM_AVG_EN`: inputs 10,20,30,40 → `data_out`=25. Inputs 65535×4 → `data_out`=65535 with no wrap. Inputs 1,1,1,2 → `data_out`=1.
- Overflow:
  - Stimulus: `out_ready`=0, 36 enabled samples (9 events).
  - Expected: `fifo_count`=8 and `overflow`=1 on the 9th event.
  - Then drain: 8 values in push order, the 9th absent.
  - `clear_ovf` pulse → `overflow`=0.
- Full with simultaneous pop: FIFO at 8, `out_ready`=1 on an event cycle → `fifo_count` stays 8, `overflow` stays 0, the new value lands at the tail. A drop coinciding with `clear_ovf` → `overflow`=1.
- Gapped input: `in_en`=1,0,1,0,… with ramp data → one push per 4 enabled cycles (every 8 clocks). Values pushed are those of enabled cycles only.
